axi_lite_master_arb: RTL and testbench

AXI_LITE_MASTER_ARB -- requirements
Module: axi_lite_master_arb

---
 rtl/axi_lite_master_arb.sv | 148 ++++++++++++++
 tb/tb_axi_lite_master_arb.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_master_arb.sv
// Two-requester AXI4-Lite master. A round-robin arbiter picks one requester
// in IDLE, then one transaction runs to completion before the next grant.
module axi_lite_master_arb (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wstrb,
  output logic [1:0]  req_done,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [31:0] AWADDR,
  output logic [2:0]  AWPROT,
  output logic        WVALID,
  input  logic        WREADY,
  output logic [31:0] WDATA,
  output logic [3:0]  WSTRB,
  input  logic        BVALID,
  output logic        BREADY,
  input  logic [1:0]  BRESP,
  output logic        ARVALID,
  input  logic        ARREADY,
  output logic [31:0] ARADDR,
  output logic [2:0]  ARPROT,
  input  logic        RVALID,
  output logic        RREADY,
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP
);

  typedef enum logic [2:0] {IDLE, WR, WB, RA, RD, RSP} state_t;

  state_t      state;
  logic        grant;   // requester owning the transaction in flight
  logic        last;    // requester granted most recently
  logic        pick;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wstrb;
  logic        sel_we;
  logic        aw_ok;
  logic        w_ok;

  assign AWPROT = '0;
  assign ARPROT = '0;

  // A channel is finished once its VALID has dropped or is handshaking now.
  assign aw_ok = !AWVALID || AWREADY;
  assign w_ok  = !WVALID  || WREADY;

  // Round-robin choice: on a tie the requester not granted last wins.
  always_comb begin
    pick = 1'b0;
    if (req_valid == 2'b11)
      pick = ~last;
    else if (req_valid[1])
      pick = 1'b1;
    sel_addr  = pick ? req_addr[63:32]  : req_addr[31:0];
    sel_wdata = pick ? req_wdata[63:32] : req_wdata[31:0];
    sel_wstrb = pick ? req_wstrb[7:4]   : req_wstrb[3:0];
    sel_we    = pick ? req_we[1]        : req_we[0];
  end

  // Transaction FSM with all AXI handshake outputs registered.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state     <= IDLE;
      grant     <= 1'b0;
      last      <= 1'b1;
      req_done  <= '0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
      AWVALID   <= 1'b0;
      AWADDR    <= '0;
      WVALID    <= 1'b0;
      WDATA     <= '0;
      WSTRB     <= '0;
      BREADY    <= 1'b0;
      ARVALID   <= 1'b0;
      ARADDR    <= '0;
      RREADY    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant <= pick;
            if (sel_we) begin
              AWADDR  <= sel_addr;
              WDATA   <= sel_wdata;
              WSTRB   <= sel_wstrb;
              AWVALID <= 1'b1;
              WVALID  <= 1'b1;
              state   <= WR;
            end else begin
              ARADDR  <= sel_addr;
              ARVALID <= 1'b1;
              state   <= RA;
            end
          end
        end
        WR: begin
          if (AWVALID && AWREADY) AWVALID <= 1'b0;
          if (WVALID && WREADY)   WVALID  <= 1'b0;
          if (aw_ok && w_ok) begin
            BREADY <= 1'b1;
            state  <= WB;
          end
        end
        WB: begin
          if (BVALID) begin
            BREADY    <= 1'b0;
            rsp_resp  <= BRESP;
            rsp_rdata <= '0;
            req_done  <= {grant, ~grant};
            state     <= RSP;
          end
        end
        RA: begin
          if (ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            state   <= RD;
          end
        end
        RD: begin
          if (RVALID) begin
            RREADY    <= 1'b0;
            rsp_rdata <= RDATA;
            rsp_resp  <= RRESP;
            req_done  <= {grant, ~grant};
            state     <= RSP;
          end
        end
        RSP: begin
          req_done <= '0;
          last     <= grant;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_master_arb.sv
// Directed bench for axi_lite_master_arb. Inputs change and outputs are
// sampled 1 time unit after each rising edge.
module tb_axi_lite_master_arb;

  logic        ACLK;
  logic        ARESETn;
  logic [1:0]  req_valid;
  logic [1:0]  req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic [1:0]  req_done;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        AWVALID, AWREADY;
  logic [31:0] AWADDR;
  logic [2:0]  AWPROT;
  logic        WVALID, WREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        BVALID, BREADY;
  logic [1:0]  BRESP;
  logic        ARVALID, ARREADY;
  logic [31:0] ARADDR;
  logic [2:0]  ARPROT;
  logic        RVALID, RREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;

  int unsigned n_cmp;
  int unsigned n_bad;

  // {AWVALID, WVALID, BREADY, ARVALID, RREADY, req_done}
  logic [6:0] hs;
  assign hs = {AWVALID, WVALID, BREADY, ARVALID, RREADY, req_done};

  axi_lite_master_arb dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_done(req_done),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  task automatic idle_inputs;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = '0;
    ARREADY = 0; RVALID = 0; RDATA = '0; RRESP = '0;
  endtask

  task automatic test_reset;
    idle_inputs();
    ARESETn = 1'b1;
    #2 ARESETn = 1'b0;
    #1;
    n_cmp++; if (hs !== 7'b0000000) begin n_bad++; $display("FAIL reset_hs: got %b expected %b", hs, 7'b0000000); end
    n_cmp++; if ({AWADDR, WDATA, ARADDR} !== 96'h0) begin n_bad++; $display("FAIL reset_payload: got %h expected 0", {AWADDR, WDATA, ARADDR}); end
    n_cmp++; if ({WSTRB, rsp_resp, rsp_rdata} !== 38'h0) begin n_bad++; $display("FAIL reset_rsp: got %h expected 0", {WSTRB, rsp_resp, rsp_rdata}); end
    n_cmp++; if ({AWPROT, ARPROT} !== 6'b0) begin n_bad++; $display("FAIL prot: got %b expected 000000", {AWPROT, ARPROT}); end
    tick();
    tick();
    ARESETn = 1'b1;
  endtask

  task automatic test_write0;
    req_valid = 2'b01; req_we = 2'b01;
    req_addr = {32'h0, 32'h0000_0010}; req_wdata = {32'h0, 32'hDEAD_BEEF}; req_wstrb = 8'h0F;
    AWREADY = 1; WREADY = 1;
    tick(); // cycle 1
    n_cmp++; if (hs !== 7'b1100000) begin n_bad++; $display("FAIL wr0_c1_hs: got %b expected %b", hs, 7'b1100000); end
    n_cmp++; if ({AWADDR, WDATA, WSTRB} !== {32'h10, 32'hDEAD_BEEF, 4'hF}) begin n_bad++; $display("FAIL wr0_payload: got %h %h %h expected 00000010 deadbeef f", AWADDR, WDATA, WSTRB); end
    tick(); // cycle 2
    n_cmp++; if (hs !== 7'b0010000) begin n_bad++; $display("FAIL wr0_c2_hs: got %b expected %b", hs, 7'b0010000); end
    AWREADY = 0; WREADY = 0; BVALID = 1; BRESP = 2'b00;
    tick(); // cycle 3
    n_cmp++; if (hs !== 7'b0000001) begin n_bad++; $display("FAIL wr0_c3_done: got %b expected %b", hs, 7'b0000001); end
    n_cmp++; if ({rsp_resp, rsp_rdata} !== 34'h0) begin n_bad++; $display("FAIL wr0_rsp: got %h expected 0", {rsp_resp, rsp_rdata}); end
    BVALID = 0; req_valid = 2'b00;
    tick();
    n_cmp++; if (hs !== 7'b0000000) begin n_bad++; $display("FAIL wr0_done_once: got %b expected %b", hs, 7'b0000000); end
  endtask

  task automatic test_read1;
    req_valid = 2'b10; req_we = 2'b00;
    req_addr = {32'h0000_0020, 32'h0}; ARREADY = 1;
    tick(); // cycle 1
    n_cmp++; if (hs !== 7'b0001000) begin n_bad++; $display("FAIL rd1_c1_hs: got %b expected %b", hs, 7'b0001000); end
    n_cmp++; if (ARADDR !== 32'h20) begin n_bad++; $display("FAIL rd1_araddr: got %h expected 00000020", ARADDR); end
    tick(); // cycle 2
    ARREADY = 0;
    req_valid = 2'b00; // withdrawal must not abort
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (hs !== 7'b0000100) begin n_bad++; $display("FAIL rd1_wait%0d: got %b expected %b", i, hs, 7'b0000100); end
      if (i < 2) tick();
    end
    RVALID = 1; RDATA = 32'h1234_5678; RRESP = 2'b00;
    tick();
    n_cmp++; if (hs !== 7'b0000010) begin n_bad++; $display("FAIL rd1_done: got %b expected %b", hs, 7'b0000010); end
    n_cmp++; if ({rsp_resp, rsp_rdata} !== {2'b00, 32'h1234_5678}) begin n_bad++; $display("FAIL rd1_rdata: got %h %h expected 0 12345678", rsp_resp, rsp_rdata); end
    RVALID = 0; RDATA = '0;
    tick();
    n_cmp++; if (hs !== 7'b0000000) begin n_bad++; $display("FAIL rd1_after: got %b expected %b", hs, 7'b0000000); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] ea, ed;
    logic [3:0]  es;
    logic [6:0]  edone;
    ARESETn = 1'b0;
    #1 ARESETn = 1'b1;
    req_valid = 2'b11; req_we = 2'b11;
    req_addr = {32'h0000_0200, 32'h0000_0100};
    req_wdata = {32'hB1B1_B1B1, 32'hA0A0_A0A0};
    req_wstrb = 8'hC3;
    AWREADY = 1; WREADY = 1;
    for (int n = 0; n < 4; n++) begin
      ea    = (n % 2 == 0) ? 32'h100 : 32'h200;
      ed    = (n % 2 == 0) ? 32'hA0A0_A0A0 : 32'hB1B1_B1B1;
      es    = (n % 2 == 0) ? 4'h3 : 4'hC;
      edone = (n % 2 == 0) ? 7'b0000001 : 7'b0000010;
      tick(); // cycle 1
      n_cmp++; if ({hs, AWADDR, WDATA, WSTRB} !== {7'b1100000, ea, ed, es}) begin n_bad++; $display("FAIL b2b%0d_issue: got %b %h %h %h expected %b %h %h %h", n, hs, AWADDR, WDATA, WSTRB, 7'b1100000, ea, ed, es); end
      tick(); // cycle 2
      n_cmp++; if (hs !== 7'b0010000) begin n_bad++; $display("FAIL b2b%0d_bready: got %b expected %b", n, hs, 7'b0010000); end
      BVALID = 1;
      tick(); // cycle 3
      n_cmp++; if (hs !== edone) begin n_bad++; $display("FAIL b2b%0d_done: got %b expected %b", n, hs, edone); end
      BVALID = 0;
      if (n == 3) req_valid = 2'b00;
      tick(); // next cycle 0
    end
    n_cmp++; if (hs !== 7'b0000000) begin n_bad++; $display("FAIL b2b_quiet: got %b expected %b", hs, 7'b0000000); end
    AWREADY = 0; WREADY = 0;
  endtask

  task automatic test_wready_delay;
    req_valid = 2'b01; req_we = 2'b01;
    req_addr = {32'h0, 32'h0000_0030}; req_wdata = {32'h0, 32'h55AA_55AA}; req_wstrb = 8'h05;
    tick(); // cycle 1
    n_cmp++; if (hs !== 7'b1100000) begin n_bad++; $display("FAIL wd_c1: got %b expected %b", hs, 7'b1100000); end
    AWREADY = 1;
    tick(); // cycle 2
    n_cmp++; if (hs !== 7'b0100000) begin n_bad++; $display("FAIL wd_c2: got %b expected %b", hs, 7'b0100000); end
    AWREADY = 0;
    tick(); // cycle 3
    n_cmp++; if ({hs, WDATA, WSTRB} !== {7'b0100000, 32'h55AA_55AA, 4'h5}) begin n_bad++; $display("FAIL wd_c3: got %b %h %h expected %b 55aa55aa 5", hs, WDATA, WSTRB, 7'b0100000); end
    WREADY = 1;
    tick(); // cycle 4
    n_cmp++; if (hs !== 7'b0010000) begin n_bad++; $display("FAIL wd_c4: got %b expected %b", hs, 7'b0010000); end
    WREADY = 0; BVALID = 1; BRESP = 2'b11;
    tick(); // cycle 5
    n_cmp++; if ({hs, rsp_resp} !== {7'b0000001, 2'b11}) begin n_bad++; $display("FAIL wd_decerr: got %b %b expected %b 11", hs, rsp_resp, 7'b0000001); end
    BVALID = 0; BRESP = '0; req_valid = 2'b00;
    tick();
  endtask

  task automatic test_reset_in_wb;
    req_valid = 2'b01; req_we = 2'b01;
    req_addr = {32'h0, 32'h0000_0040}; req_wdata = {32'h0, 32'h0BAD_F00D}; req_wstrb = 8'h0F;
    AWREADY = 1; WREADY = 1;
    tick();
    tick(); // in WB, no BVALID
    n_cmp++; if (hs !== 7'b0010000) begin n_bad++; $display("FAIL rst_wb_pre: got %b expected %b", hs, 7'b0010000); end
    #2 ARESETn = 1'b0;
    #1;
    n_cmp++; if (hs !== 7'b0000000) begin n_bad++; $display("FAIL rst_wb_hs: got %b expected %b", hs, 7'b0000000); end
    n_cmp++; if ({AWADDR, WDATA, WSTRB, rsp_resp} !== 70'h0) begin n_bad++; $display("FAIL rst_wb_regs: got %h expected 0", {AWADDR, WDATA, WSTRB, rsp_resp}); end
    req_addr = {32'h0, 32'h0000_0044}; req_wdata = {32'h0, 32'h1122_3344};
    @(negedge ACLK);
    ARESETn = 1'b1;
    tick(); // cycle 1 of the new write
    n_cmp++; if ({hs, AWADDR, WDATA} !== {7'b1100000, 32'h44, 32'h1122_3344}) begin n_bad++; $display("FAIL rst_new_issue: got %b %h %h expected %b 00000044 11223344", hs, AWADDR, WDATA, 7'b1100000); end
    tick();
    AWREADY = 0; WREADY = 0; BVALID = 1; BRESP = 2'b10;
    tick();
    n_cmp++; if ({hs, rsp_resp} !== {7'b0000001, 2'b10}) begin n_bad++; $display("FAIL rst_new_slverr: got %b %b expected %b 10", hs, rsp_resp, 7'b0000001); end
    BVALID = 0; req_valid = 2'b00;
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_write0();
    test_read1();
    test_back_to_back();
    test_wready_delay();
    test_reset_in_wb();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
